// File: rtl/multiplier2_pkg.sv
// Shared types and constants for the multiplier2 shift-and-add multiplier.
package multiplier2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // The iteration counter must be able to hold WIDTH itself, which is why the +1 is there.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/multiplier2_ctrl.sv
// Sequencing FSM and iteration counter for multiplier2.
// Optional feature macro: MULTIPLIER2_EARLY_DONE_EN (adds finish_early input and cnt_out output).
//
// state | meaning
// IDLE  | out of reset, Product = 0, ready = 1
// BUSY  | one shift-and-add step per clock
// DONE  | Product holds the last result, ready = 1
module multiplier2_ctrl
    import multiplier2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
`ifdef MULTIPLIER2_EARLY_DONE_EN
    input  logic                        finish_early,
    output logic [cnt_width(WIDTH)-1:0] cnt_out,
`endif
    output logic                        load,
    output logic                        step,
    output logic                        ready
);

    localparam int CW = cnt_width(WIDTH);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;

    // Capture happens from either idle state; BUSY ignores start entirely.
    assign load = (state != BUSY) && start;
    assign step = (state == BUSY);

`ifdef MULTIPLIER2_EARLY_DONE_EN
    assign cnt_out = cnt;
    assign last    = (cnt == CW'(WIDTH - 1)) || finish_early;
`else
    assign last    = (cnt == CW'(WIDTH - 1));
`endif

    // State, counter and registered ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ready <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= BUSY;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/multiplier2.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier, one partial product per clock.
// Optional feature macro: MULTIPLIER2_EARLY_DONE_EN (finish as soon as the remaining
// multiplier bits are all zero; the product value is unchanged).
module multiplier2
    import multiplier2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] Product,
    output logic               ready
);

    localparam int CW = cnt_width(WIDTH);

    logic               load;
    logic               step;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] acc_next;

`ifdef MULTIPLIER2_EARLY_DONE_EN
    logic               finish_early;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      rem_cnt;
    logic [WIDTH-1:0]   rem_mask;
`endif

    multiplier2_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
`ifdef MULTIPLIER2_EARLY_DONE_EN
        .finish_early (finish_early),
        .cnt_out      (cnt),
`endif
        .load         (load),
        .step         (step),
        .ready        (ready)
    );

    // One iteration: conditional add into the upper half, then shift {carry, acc} right by one.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_step = {sum, acc[WIDTH-1:1]};
    end

`ifdef MULTIPLIER2_EARLY_DONE_EN
    // After cnt shifts, the unprocessed multiplier bits sit in the low WIDTH-cnt bits of acc.
    // If they are all zero no more adds will happen, so the remaining shifts collapse into one.
    always_comb begin
        rem_cnt      = CW'(WIDTH) - cnt;
        rem_mask     = {WIDTH{1'b1}} >> cnt;
        finish_early = ((acc[WIDTH-1:0] & rem_mask) == '0);
        acc_next     = finish_early ? (acc >> rem_cnt) : acc_step;
    end
`else
    always_comb begin
        acc_next = acc_step;
    end
`endif

    // Datapath registers: operands captured on load, accumulator advanced on each step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            acc   <= '0;
        end else if (load) begin
            mcand <= A;
            acc   <= {{WIDTH{1'b0}}, B};
        end else if (step) begin
            acc   <= acc_next;
        end
    end

    assign Product = acc;

endmodule

// File: tb/tb_multiplier2.sv
// Self-checking bench for multiplier2 (default build, fixed WIDTH+1-edge latency).
module tb_multiplier2;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic [2*W-1:0] Product;
    logic           ready;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    multiplier2 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (A),
        .B       (B),
        .Product (Product),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    // Reference model: a multiplication launched from ready takes W further edges;
    // the product A*B appears with ready and holds until the next launch.
    logic           m_ready = 1'b1;
    logic [2*W-1:0] m_prod  = '0;
    logic [2*W-1:0] m_pend  = '0;
    int             m_left  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready <= 1'b1;
            m_prod  <= '0;
            m_left  <= 0;
        end else if (m_left == 0 && start) begin
            m_pend  <= {8'h00, A} * {8'h00, B};
            m_left  <= W;
            m_ready <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_ready <= 1'b1;
                m_prod  <= m_pend;
            end
        end
    end

    task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ready", {15'h0, ready}, {15'h0, m_ready});
            if (m_ready) check("model_product", Product, m_prod);
        end
    end

    // Pulse start for one capture edge, then verify latency and result at edge W+1.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input string name);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (W - 1) @(posedge clk);
        #1 check({name, "_busy_edge8"}, {15'h0, ready}, 16'h0000);
        @(posedge clk); #1;
        check({name, "_ready"}, {15'h0, ready}, 16'h0001);
        check({name, "_product"}, Product, exp);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1 check("reset_product", Product, 16'h0000);
        check("reset_ready", {15'h0, ready}, 16'h0001);
        @(posedge clk); #1 rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Reset mid-operation after three step edges.
        A = 8'h12; B = 8'h34; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 check("midreset_product", Product, 16'h0000);
        check("midreset_ready", {15'h0, ready}, 16'h0001);
        @(posedge clk); #1 rst = 1'b0;
        run_op(8'h12, 8'h34, 16'h03A8, "after_reset");

        // Corners.
        run_op(8'hFF, 8'hFF, 16'hFE01, "ff_ff");
        run_op(8'h00, 8'h5A, 16'h0000, "zero_a");
        run_op(8'h01, 8'hAB, 16'h00AB, "one_a");
        run_op(8'h80, 8'h02, 16'h0100, "msb_a");

        // Operands go X right after capture.
        A = 8'h0D; B = 8'h0B; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        A = 'x; B = 'x;
        repeat (W) @(posedge clk);
        #1 check("isolation_product", Product, 16'h008F);
        check("isolation_ready", {15'h0, ready}, 16'h0001);

        // Start pulse during BUSY at edge 4 is ignored.
        A = 8'h03; B = 8'h05; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 A = 8'hFF; B = 8'hFF; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (W - 3) @(posedge clk);
        #1 check("busy_start_product", Product, 16'h000F);
        check("busy_start_ready", {15'h0, ready}, 16'h0001);

        // Back-to-back with start held high: second capture on the edge after ready rises.
        A = 8'h07; B = 8'h09; start = 1'b1;
        @(posedge clk); #1 A = 8'h10; B = 8'h10;
        repeat (W) @(posedge clk);
        #1 check("b2b_first_product", Product, 16'h003F);
        check("b2b_first_ready", {15'h0, ready}, 16'h0001);
        @(posedge clk); #1 start = 1'b0;
        check("b2b_second_busy", {15'h0, ready}, 16'h0000);
        repeat (W) @(posedge clk);
        #1 check("b2b_second_product", Product, 16'h0100);
        check("b2b_second_ready", {15'h0, ready}, 16'h0001);

        // Random regression.
        for (int i = 0; i < 100; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            run_op(ra, rb, {8'h00, ra} * {8'h00, rb}, "random");
            @(posedge clk); #1;
            check("random_hold", Product, {8'h00, ra} * {8'h00, rb});
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
